// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst from a show-ahead FIFO onto a registered valid/ready stream, one cycle pop-to-valid, pops only when the output slot frees.
// Optional RDR_STALL_CNT_EN adds a saturating count of RUN cycles spent waiting on an empty FIFO.
module fifo_burst_reader #(
  parameter int DSIZE = 8,
  parameter int LSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             req_valid,
  input  logic [LSIZE-1:0] req_len,
  output logic             req_ready,
  input  logic             abort,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             aborted
`ifdef RDR_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state;
  logic [LSIZE-1:0] remaining;
  logic             aborted_q;

  // Pop only when the output register is free or being emptied this cycle.
  assign rinc = (state == RUN) && !rempty && (remaining != '0) &&
                (!out_valid || out_ready) && !abort;

  assign req_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign aborted   = aborted_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state     <= IDLE;
      remaining <= '0;
      aborted_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining <= req_len;
            aborted_q <= 1'b0;
            state     <= (req_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (rinc) begin
            out_data  <= rdata;
            out_valid <= 1'b1;
            remaining <= remaining - 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (abort) begin
            aborted_q <= 1'b1;
            state     <= FLUSH;
          end else if (rinc && (remaining == LSIZE'(1))) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          aborted_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RDR_STALL_CNT_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      stall_cnt <= '0;
    end else if (state == RUN && rempty && remaining != '0 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, word scoreboard, table of bursts plus stall/abort/reset sequences.
module tb_fifo_burst_reader;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_len = '0;
  logic       req_ready;
  logic       abort = 1'b0;
  logic [7:0] rdata;
  logic       rempty;
  logic       rinc;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       done;
  logic       aborted;
`ifdef RDR_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fifo_burst_reader #(.DSIZE(8), .LSIZE(8)) dut (
    .rclk(rclk), .rrst(rrst), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .abort(abort), .rdata(rdata), .rempty(rempty),
    .rinc(rinc), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .aborted(aborted)
`ifdef RDR_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  // Show-ahead FIFO model
  logic [7:0]  mem [0:255];
  logic [15:0] wr_ptr = '0;
  logic [15:0] rd_ptr = '0;
  logic        fifo_clr = 1'b0;
  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr[7:0]];
  always @(posedge rclk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (rinc && !rempty) rd_ptr <= rd_ptr + 16'd1;
  end

  typedef struct {
    int len; int preload; int base; bit tog;
    int exp_pops; int exp_left; int exp_lat;
  } vec_t;
  vec_t vecs [5];

  logic [7:0] exp_q [$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, rinc_cnt, first_pop, last_pop, done_cnt, done_cyc, done_ab;
  int nrdy_cnt, stall_exp, cur_len, req_cyc;
  bit bench_run = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic int level();
    return int'(16'(wr_ptr - rd_ptr));
  endfunction

  task automatic push_word(input logic [7:0] d, input bit expect_out);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 16'd1;
    if (expect_out) exp_q.push_back(d);
  endtask

  // Samples the cycle at the falling edge, then returns just after the next rising edge.
  task automatic tick();
    @(negedge rclk);
    cyc++;
    if (rinc) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      rinc_cnt++;
    end
    if (rempty) check("no_underflow", int'(rinc), 0);
    if (bench_run && rempty) stall_exp++;
    if (rinc && rinc_cnt == cur_len) bench_run = 1'b0;
    if (!req_ready) nrdy_cnt++;
    if (done) begin
      done_cnt++; done_cyc = cyc; done_ab = int'(aborted);
    end
    if (prev_stall) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), int'(prev_data));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_word", int'(out_data), -1);
      else check("word", int'(out_data), int'(exp_q.pop_front()));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge rclk);
    #1;
  endtask

  task automatic start_req(input int len);
    rinc_cnt = 0; first_pop = -1; last_pop = -1; done_cnt = 0; done_cyc = -1;
    done_ab = -1; nrdy_cnt = 0; stall_exp = 0; cur_len = len;
    req_cyc = cyc + 1;
    req_valid = 1'b1;
    req_len = 8'(len);
    tick();
    req_valid = 1'b0;
    bench_run = (len != 0);
  endtask

  task automatic wait_done(input int budget, input bit tog);
    for (int n = 0; n < budget && done_cnt == 0; n++) begin
      if (tog) out_ready = ~out_ready;
      tick();
    end
    check("done_seen", done_cnt, 1);
    check("idle_after_done", int'(req_ready), 1);
  endtask

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{len: 5,   preload: 5,   base: 'h10, tog: 1'b0, exp_pops: 5,   exp_left: 0, exp_lat: 2};
    vecs[1] = '{len: 4,   preload: 4,   base: 'hA0, tog: 1'b1, exp_pops: 4,   exp_left: 0, exp_lat: -1};
    vecs[2] = '{len: 0,   preload: 0,   base: 'h00, tog: 1'b0, exp_pops: 0,   exp_left: 0, exp_lat: 1};
    vecs[3] = '{len: 1,   preload: 3,   base: 'h55, tog: 1'b0, exp_pops: 1,   exp_left: 2, exp_lat: 2};
    vecs[4] = '{len: 255, preload: 255, base: 'h01, tog: 1'b0, exp_pops: 255, exp_left: 0, exp_lat: 2};

    // Reset state
    repeat (2) tick();
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_rinc", int'(rinc), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
`ifdef RDR_STALL_CNT_EN
    check("rst_stall_cnt", int'(stall_cnt), 0);
`endif
    rrst = 1'b0;
    tick();

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < vecs[r].preload; i++)
        push_word(8'((vecs[r].base + i) & 255), i < vecs[r].len);
      out_ready = 1'b1;
      start_req(vecs[r].len);
      wait_done(600, vecs[r].tog);
      check("pops", rinc_cnt, vecs[r].exp_pops);
      check("aborted_flag", done_ab, 0);
      check("fifo_left", level(), vecs[r].exp_left);
      check("scoreboard_empty", exp_q.size(), 0);
      check("busy_cycles", nrdy_cnt, done_cyc - req_cyc);
      if (vecs[r].exp_pops > 0 && !vecs[r].tog)
        check("pops_back_to_back", last_pop - first_pop + 1, vecs[r].exp_pops);
      if (vecs[r].exp_lat >= 0)
        check("done_latency", done_cyc - ((vecs[r].len > 0) ? last_pop : req_cyc), vecs[r].exp_lat);
      out_ready = 1'b1;
      clear_fifo();
    end

    // Abort while idle must not start anything
    abort = 1'b1;
    done_cnt = 0; nrdy_cnt = 0;
    repeat (2) tick();
    abort = 1'b0;
    check("idle_abort_done", done_cnt, 0);
    check("idle_abort_busy", nrdy_cnt, 0);

    // FIFO runs dry mid-burst; a stray request during RUN is ignored
    push_word(8'h30, 1'b1);
    push_word(8'h31, 1'b1);
    out_ready = 1'b1;
    start_req(6);
    for (int n = 0; n < 20; n++) begin
      req_valid = (n == 10);
      req_len   = 8'd3;
      tick();
    end
    req_valid = 1'b0;
    check("stall_pops", rinc_cnt, 2);
    check("stall_no_done", done_cnt, 0);
    for (int i = 0; i < 3; i++) push_word(8'(8'h32 + i), 1'b1);
    repeat (4) tick();
    check("resume_pops", rinc_cnt, 5);
    check("resume_no_done", done_cnt, 0);
    push_word(8'h35, 1'b1);
    wait_done(20, 1'b0);
    check("stall_total_pops", rinc_cnt, 6);
    check("stall_aborted", done_ab, 0);
    check("stall_scoreboard", exp_q.size(), 0);
`ifdef RDR_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), stall_exp);
`endif

    // Abort after the third pop with downstream stalled
    for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i), i < 3);
    out_ready = 1'b1;
    start_req(8);
    for (int n = 0; n < 20 && rinc_cnt < 3; n++) tick();
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bench_run = 1'b0;
    repeat (3) tick();
    check("abort_pops", rinc_cnt, 3);
    check("abort_held", done_cnt, 0);
    out_ready = 1'b1;
    wait_done(10, 1'b0);
    check("abort_flag", done_ab, 1);
    check("abort_pops_final", rinc_cnt, 3);
    check("abort_fifo_left", level(), 5);
    check("abort_scoreboard", exp_q.size(), 0);
    check("abort_flag_cleared", int'(aborted), 0);
    clear_fifo();

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) push_word(8'(8'h60 + i), 1'b1);
    out_ready = 1'b1;
    start_req(5);
    for (int n = 0; n < 20 && rinc_cnt < 2; n++) tick();
    rrst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_rinc", int'(rinc), 0);
    check("mid_rst_req_ready", int'(req_ready), 1);
`ifdef RDR_STALL_CNT_EN
    check("mid_rst_stall_cnt", int'(stall_cnt), 0);
`endif
    exp_q.delete();
    prev_stall = 1'b0;
    bench_run = 1'b0;
    repeat (2) tick();
    rrst = 1'b0;
    repeat (4) tick();
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_pops", rinc_cnt, 2);
    clear_fifo();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
